// File: rtl/if_fetch_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_unit_if : instruction-memory request/acknowledge bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface if_fetch_unit_if #(
   parameter int DATA_W = 16
);
   logic              imem_req;
   logic [DATA_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_data;

   // Fetch unit side
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   // Instruction memory side
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );
endinterface
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_fetch_unit : PC owner, imem req/ack fetch, one-entry buffer feeding IF/ID
// Rev 1.0
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              stall_in,
   input  logic              branch_taken,
   input  logic [DATA_W-1:0] branch_target,
   if_fetch_unit_if.master   imem,
   output logic [DATA_W-1:0] instr_out,
   output logic [DATA_W-1:0] pcplus2_out,
   output logic              if_flush,
   output logic              if_freze
);

   localparam logic [DATA_W-1:0] c_pc_step = DATA_W'(2);

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_REQ  = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t            r_state,     w_state_nxt;
   logic [DATA_W-1:0] r_req_addr,  w_req_addr_nxt;
   logic [DATA_W-1:0] r_pend_addr, w_pend_addr_nxt;
   logic              r_buf_valid, w_buf_valid_nxt;
   logic [DATA_W-1:0] r_buf_instr, w_buf_instr_nxt;
   logic [DATA_W-1:0] r_buf_pc2,   w_buf_pc2_nxt;

   logic              w_consume;
   logic [DATA_W-1:0] w_req_inc;

   assign w_consume = r_buf_valid & ~stall_in & ~branch_taken;
   assign w_req_inc = r_req_addr + c_pc_step;

   assign imem.imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
   assign imem.imem_addr = r_req_addr;
   assign instr_out      = r_buf_instr;
   assign pcplus2_out    = r_buf_pc2;

   // Branch always beats stall
   assign if_freze = stall_in & ~branch_taken;
   assign if_flush = branch_taken | (~stall_in & ~r_buf_valid);

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         r_state     <= S_HOLD;
         r_req_addr  <= RESET_PC;
         r_pend_addr <= '0;
         r_buf_valid <= 1'b0;
         r_buf_instr <= '0;
         r_buf_pc2   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_addr  <= w_req_addr_nxt;
         r_pend_addr <= w_pend_addr_nxt;
         r_buf_valid <= w_buf_valid_nxt;
         r_buf_instr <= w_buf_instr_nxt;
         r_buf_pc2   <= w_buf_pc2_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_req_addr_nxt  = r_req_addr;
      w_pend_addr_nxt = r_pend_addr;
      w_buf_valid_nxt = r_buf_valid;
      w_buf_instr_nxt = r_buf_instr;
      w_buf_pc2_nxt   = r_buf_pc2;

      case (r_state)
         S_HOLD: begin
            if (branch_taken) begin
               w_buf_valid_nxt = 1'b0;
               w_req_addr_nxt  = branch_target;
               w_state_nxt     = S_REQ;
            end else if (!r_buf_valid || w_consume) begin
               w_buf_valid_nxt = 1'b0;
               w_state_nxt     = S_REQ;
            end
         end

         S_REQ: begin
            if (branch_taken && imem.imem_ack) begin
               w_buf_valid_nxt = 1'b0;
               w_req_addr_nxt  = branch_target;
            end else if (branch_taken) begin
               // Address must stay stable until the in-flight ack returns
               w_buf_valid_nxt = 1'b0;
               w_pend_addr_nxt = branch_target;
               w_state_nxt     = S_DROP;
            end else if (imem.imem_ack) begin
               w_buf_instr_nxt = imem.imem_data;
               w_buf_pc2_nxt   = w_req_inc;
               w_req_addr_nxt  = w_req_inc;
               w_buf_valid_nxt = 1'b1;
               w_state_nxt     = S_HOLD;
            end
         end

         S_DROP: begin
            if (branch_taken) begin
               w_pend_addr_nxt = branch_target;
            end
            if (imem.imem_ack) begin
               w_req_addr_nxt = branch_taken ? branch_target : r_pend_addr;
               w_state_nxt    = S_REQ;
            end
         end

         default: begin
            w_state_nxt = S_HOLD;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_fetch_unit : directed stimulus with queue-based scoreboard for if_fetch_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rest;
   logic        stall_in, branch_taken;
   logic [15:0] branch_target;
   logic [15:0] instr_out, pcplus2_out;
   logic        if_flush, if_freze;

   logic        stall2, branch2;
   logic [15:0] target2;
   logic [15:0] instr2, pc2_2;
   logic        flush2, freze2;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] exp_addr[$];
   logic [31:0] exp_instr[$];

   always #5 clk = ~clk;

   if_fetch_unit_if #(.DATA_W(16)) bus  ();
   if_fetch_unit_if #(.DATA_W(16)) bus2 ();

   if_fetch_unit #(.DATA_W(16), .RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rest          (rest),
      .stall_in      (stall_in),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem          (bus),
      .instr_out     (instr_out),
      .pcplus2_out   (pcplus2_out),
      .if_flush      (if_flush),
      .if_freze      (if_freze)
   );

   // Second instance exercises the address wrap from the top of memory
   if_fetch_unit #(.DATA_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
      .clk           (clk),
      .rest          (rest),
      .stall_in      (stall2),
      .branch_taken  (branch2),
      .branch_target (target2),
      .imem          (bus2),
      .instr_out     (instr2),
      .pcplus2_out   (pc2_2),
      .if_flush      (flush2),
      .if_freze      (freze2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops expectations whenever a new request starts or IF/ID loads a valid instruction
   initial begin : monitor
      logic        req_seen;
      logic [15:0] held_addr;
      logic [15:0] ea;
      logic [31:0] ei;
      req_seen  = 1'b0;
      held_addr = '0;
      forever begin
         @(negedge clk);
         if (rest) begin
            req_seen = 1'b0;
         end else begin
            if (bus.imem_req) begin
               if (!req_seen) begin
                  if (exp_addr.size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL req_addr: unexpected request at %h, none expected", bus.imem_addr);
                  end else begin
                     ea = exp_addr.pop_front();
                     check("req_addr", {16'h0, bus.imem_addr}, {16'h0, ea});
                  end
                  held_addr = bus.imem_addr;
                  req_seen  = 1'b1;
               end else begin
                  check("req_addr_stable", {16'h0, bus.imem_addr}, {16'h0, held_addr});
               end
               if (bus.imem_ack) req_seen = 1'b0;
            end
            if (!if_flush && !if_freze) begin
               if (exp_instr.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL ifid_load: unexpected instr %h pc2 %h, none expected", instr_out, pcplus2_out);
               end else begin
                  ei = exp_instr.pop_front();
                  check("ifid_load", {instr_out, pcplus2_out}, ei);
               end
            end
         end
      end
   end

   initial begin : stim
      rest = 1'b1;
      stall_in = 1'b0; branch_taken = 1'b0; branch_target = '0;
      bus.imem_ack = 1'b0; bus.imem_data = '0;
      stall2 = 1'b0; branch2 = 1'b0; target2 = '0;
      bus2.imem_ack = 1'b0; bus2.imem_data = '0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req",   {31'h0, bus.imem_req}, 32'h0);
      check("rst_addr",  {16'h0, bus.imem_addr}, 32'h0000);
      check("rst_instr", {16'h0, instr_out}, 32'h0);
      check("rst_pc2",   {16'h0, pcplus2_out}, 32'h0);
      check("rst_addr_wrap", {16'h0, bus2.imem_addr}, 32'hFFFE);
      next();

      // Release reset: one HOLD cycle, then first request at 0x0000
      rest = 1'b0;
      exp_addr.push_back(16'h0000);
      @(negedge clk);
      check("hold_flush", {31'h0, if_flush}, 32'h1);
      check("hold_req",   {31'h0, bus.imem_req}, 32'h0);
      next();

      // Zero-wait ack
      bus.imem_ack = 1'b1; bus.imem_data = 16'h1234;
      exp_instr.push_back({16'h1234, 16'h0002});
      next();
      bus.imem_ack = 1'b0;
      exp_addr.push_back(16'h0002);
      @(negedge clk);
      check("zw_flush", {31'h0, if_flush}, 32'h0);
      check("zw_instr", {16'h0, instr_out}, 32'h1234);
      next();

      // Fetch 0x5678 then stall three cycles
      bus.imem_ack = 1'b1; bus.imem_data = 16'h5678;
      exp_instr.push_back({16'h5678, 16'h0004});
      next();
      bus.imem_ack = 1'b0;
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_freze", {31'h0, if_freze}, 32'h1);
         check("stall_flush", {31'h0, if_flush}, 32'h0);
         check("stall_req",   {31'h0, bus.imem_req}, 32'h0);
         check("stall_instr", {16'h0, instr_out}, 32'h5678);
         next();
      end
      stall_in = 1'b0;
      exp_addr.push_back(16'h0004);
      @(negedge clk);
      check("unstall_req", {31'h0, bus.imem_req}, 32'h0);
      next();

      // Fetch 0x1111, then branch to 0x0010 from HOLD drops it
      bus.imem_ack = 1'b1; bus.imem_data = 16'h1111;
      @(negedge clk);
      check("unstall_req_up", {31'h0, bus.imem_req}, 32'h1);
      next();
      bus.imem_ack = 1'b0;
      branch_taken = 1'b1; branch_target = 16'h0010;
      exp_addr.push_back(16'h0010);
      @(negedge clk);
      check("brhold_flush", {31'h0, if_flush}, 32'h1);
      check("brhold_freze", {31'h0, if_freze}, 32'h0);
      next();
      branch_taken = 1'b0;
      next();

      // Branch to 0x0040 while request at 0x0010 is outstanding
      branch_taken = 1'b1; branch_target = 16'h0040;
      exp_addr.push_back(16'h0040);
      @(negedge clk);
      check("brreq_flush", {31'h0, if_flush}, 32'h1);
      next();
      branch_taken = 1'b0;
      @(negedge clk);
      check("drop_addr", {16'h0, bus.imem_addr}, 32'h0010);
      next();
      bus.imem_ack = 1'b1; bus.imem_data = 16'hBEEF;
      next();
      bus.imem_ack = 1'b1; bus.imem_data = 16'h2222;
      @(negedge clk);
      check("drop_discard", {16'h0, instr_out}, 32'h1111);
      check("redirect_addr", {16'h0, bus.imem_addr}, 32'h0040);
      next();

      // Branch and stall together with buffer full
      bus.imem_ack = 1'b0;
      stall_in = 1'b1; branch_taken = 1'b1; branch_target = 16'h0080;
      exp_addr.push_back(16'h0080);
      @(negedge clk);
      check("brstall_flush", {31'h0, if_flush}, 32'h1);
      check("brstall_freze", {31'h0, if_freze}, 32'h0);
      check("brstall_instr", {16'h0, instr_out}, 32'h2222);
      next();
      stall_in = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      check("brstall_bufclr", {31'h0, if_flush}, 32'h1);
      check("brstall_addr", {16'h0, bus.imem_addr}, 32'h0080);
      next();

      // Branch coinciding with ack in REQ
      branch_taken = 1'b1; branch_target = 16'h00A0;
      bus.imem_ack = 1'b1; bus.imem_data = 16'h3333;
      exp_addr.push_back(16'h00A0);
      next();
      // Two branches while dropping: latest target wins
      bus.imem_ack = 1'b0; branch_target = 16'h00C0;
      @(negedge clk);
      check("brack_discard", {16'h0, instr_out}, 32'h2222);
      next();
      branch_target = 16'h00E0;
      next();
      branch_taken = 1'b0;
      bus.imem_ack = 1'b1; bus.imem_data = 16'h5555;
      exp_addr.push_back(16'h00E0);
      next();
      bus.imem_data = 16'h4444;
      exp_instr.push_back({16'h4444, 16'h00E2});
      next();
      bus.imem_ack = 1'b0;
      exp_addr.push_back(16'h00E2);
      next();
      next();

      // Reset asserted mid-request
      rest = 1'b1;
      @(negedge clk);
      check("midrst_req",   {31'h0, bus.imem_req}, 32'h0);
      check("midrst_instr", {16'h0, instr_out}, 32'h0);
      check("midrst_pc2",   {16'h0, pcplus2_out}, 32'h0);
      check("midrst_addr",  {16'h0, bus.imem_addr}, 32'h0000);
      next();
      rest = 1'b0;
      bus.imem_ack = 1'b1; bus.imem_data = 16'hDEAD;
      exp_addr.push_back(16'h0000);
      @(negedge clk);
      check("postrst_req", {31'h0, bus.imem_req}, 32'h0);
      next();
      bus.imem_ack = 1'b0;
      bus2.imem_ack = 1'b1; bus2.imem_data = 16'hA5A5;
      @(negedge clk);
      check("stale_ack_ignored", {16'h0, instr_out}, 32'h0);
      check("wrap_req",  {31'h0, bus2.imem_req}, 32'h1);
      check("wrap_addr", {16'h0, bus2.imem_addr}, 32'hFFFE);
      next();
      bus2.imem_ack = 1'b0;
      bus.imem_ack = 1'b1; bus.imem_data = 16'h9999;
      exp_instr.push_back({16'h9999, 16'h0002});
      @(negedge clk);
      check("wrap_instr", {16'h0, instr2}, 32'hA5A5);
      check("wrap_pc2",   {16'h0, pc2_2}, 32'h0000);
      check("wrap_flush", {31'h0, flush2}, 32'h0);
      next();
      bus.imem_ack = 1'b0;
      exp_addr.push_back(16'h0002);
      @(negedge clk);
      check("wrap_next_addr", {16'h0, bus2.imem_addr}, 32'h0000);
      check("wrap_next_req",  {31'h0, bus2.imem_req}, 32'h1);
      next();
      repeat (3) next();

      check("addr_queue_drained",  exp_addr.size(), 0);
      check("instr_queue_drained", exp_instr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end that writes the IF/ID pipeline register. It owns the PC, runs a request/acknowledge transaction to instruction memory, and holds one fetched instruction in a buffer. Toward IF/ID it drives the instruction word, PC+2, and the Flush/Freze controls, applying stall from the hazard unit and redirect from branch resolution.

Parameters:
DATA_W, 16, instruction and address width.
RESET_PC, 16'h0000, first fetch address after reset.

Ports:
clk  in  1  system clock, rising edge.
rest  in  1  asynchronous active-high reset.
stall_in  in  1  hazard-unit stall request; ID must hold.
branch_taken  in  1  redirect request from branch resolution, single-cycle.
branch_target  in  DATA_W  redirect address, valid with branch_taken.
imem_req  out  1  memory request; held high until imem_ack.
imem_addr  out  DATA_W  request address; stable while imem_req is high.
imem_ack  in  1  one-cycle response strobe; imem_data is valid in that cycle.
imem_data  in  DATA_W  fetched instruction.
instr_out  out  DATA_W  instruction to IF/ID Source input.
pcplus2_out  out  DATA_W  fetch address + 2 to IF/ID PCPlus2 input.
if_flush  out  1  Flush to IF/ID (load a bubble).
if_freze  out  1  Freze to IF/ID (hold contents).

Behaviour:
- Registers: state, req_addr, pend_addr, buf_valid, buf_instr, buf_pc2.
- Combinational outputs:
  - imem_addr = req_addr.
  - instr_out = buf_instr.
  - pcplus2_out = buf_pc2.
  - imem_req = (state is S_REQ or S_DROP).
- Control:
  - consume = buf_valid & !stall_in & !branch_taken.
  - if_freze = stall_in & !branch_taken.
  - if_flush = branch_taken | (!stall_in & !buf_valid).
  - Branch always beats stall.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = S_HOLD, req_addr = RESET_PC, pend_addr = 0, buf_valid = 0, buf_instr = 0, buf_pc2 = 0.
  - Resulting outputs: imem_req = 0, imem_addr = RESET_PC, instr_out = 0, pcplus2_out = 0.
  - A memory ack that arrives after reset is released is ignored unless state is S_REQ or S_DROP.
- S_HOLD:
  - branch_taken: buf_valid <= 0, req_addr <= branch_target, go to S_REQ.
  - Otherwise, if !buf_valid or consume: buf_valid <= 0, go to S_REQ.
  - Otherwise stay; the buffer holds stable.
- S_REQ (ack may arrive in the first cycle req is high):
  - branch_taken & imem_ack: discard data, buf_valid <= 0, req_addr <= branch_target, stay in S_REQ (new address next cycle).
  - branch_taken & !imem_ack: buf_valid <= 0, pend_addr <= branch_target, go to S_DROP. req_addr is unchanged because the request must stay stable.
  - imem_ack, no branch: buf_instr <= imem_data, buf_pc2 <= req_addr+2, req_addr <= req_addr+2, buf_valid <= 1, go to S_HOLD.
- S_DROP (outstanding response is to be discarded):
  - branch_taken: pend_addr <= branch_target (latest wins).
  - imem_ack: discard data, req_addr <= (branch_taken ? branch_target : pend_addr), go to S_REQ.
- Arithmetic: +2 is modulo 2^DATA_W (16'hFFFE + 2 = 16'h0000). Address bit 0 is passed through unchecked.
- Throughput: with a zero-wait memory, one instruction every 2 cycles. One transaction is outstanding at most.
- Buffer contents change only on an accepted ack or on reset. A branch clears only buf_valid.

Test Plan:
1. Reset mid-request: rest asserted while imem_req=1 -> imem_req=0, instr_out=0, pcplus2_out=0, imem_addr=RESET_PC in the same cycle; after release, req rises with addr 0x0000.
2. Zero-wait straight line: ack in the first req cycle with data 0x1234 at 0x0000 -> next cycle instr_out=0x1234, pcplus2_out=0x0002, if_flush=0; following cycle req with addr 0x0002.
3. Stall: buffer full, stall_in high 3 cycles -> if_freze=1, if_flush=0, imem_req=0, instr_out stable; in the cycle stall drops, consume occurs and req rises the next cycle.
4. Branch with outstanding request: branch_target=0x0040 while req at 0x0010 is pending, ack 2 cycles later with 0xBEEF -> if_flush=1 in the branch cycle, 0xBEEF never appears on instr_out, next req addr=0x0040.
5. Wrap: RESET_PC=16'hFFFE, ack data 0xA5A5 -> pcplus2_out=0x0000, next imem_addr=0x0000.
6. Simultaneous branch_taken and stall_in with buffer full -> if_flush=1, if_freze=0, buf_valid cleared, next req addr=branch_target.
